// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, Tnew/write-enable helpers and bubble constant for the stage chain
package pipe_pkg;

  localparam int TNEW_W_DEF = 2;
  localparam int ADDR_W_DEF = 5;
  // Widest Tnew counter the helper supports; callers size-cast in and out.
  localparam int TNEW_MAX_W = 8;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [TNEW_W_DEF-1:0] tnew;
  } desc_t;

  localparam desc_t DESC_BUBBLE = '0;

  function automatic logic [TNEW_MAX_W-1:0] sat_dec(input logic [TNEW_MAX_W-1:0] x);
    sat_dec = (x == '0) ? '0 : x - 1'b1;
  endfunction

  function automatic logic eff_we(input logic valid, input logic we, input logic addr_nz);
    eff_we = valid & we & addr_nz;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one pipeline stage register holding payload and register-write descriptor
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [TNEW_W-1:0] tnew
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;

  // Flush beats hold, hold beats bubble insertion, bubble beats load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    we_d    = we_q;
    addr_d  = addr_q;
    tnew_d  = tnew_q;
    if (flush || (!hold && bubble)) begin
      valid_d = DESC_BUBBLE.valid;
      data_d  = '0;
      we_d    = DESC_BUBBLE.we;
      addr_d  = ADDR_W'(DESC_BUBBLE.addr);
      tnew_d  = TNEW_W'(DESC_BUBBLE.tnew);
    end else if (!hold && load) begin
      valid_d = in_valid;
      data_d  = in_data;
      we_d    = in_we;
      addr_d  = in_addr;
      tnew_d  = in_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      tnew_q  <= tnew_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign tnew  = tnew_q;

endmodule

// File: rtl/hazard_pipe_chain.sv
// rtl/hazard_pipe_chain.sv - DEPTH-stage pipeline register chain with stall/flush and hazard export
module hazard_pipe_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 96,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [TNEW_W-1:0]        in_tnew,
  input  logic [DEPTH-1:0]         stall,
  input  logic [DEPTH-1:0]         flush,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_we,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DEPTH-1:0]         hz_we,
  output logic [DEPTH*ADDR_W-1:0]  hz_addr,
  output logic [DEPTH*TNEW_W-1:0]  hz_tnew,
  output logic [DEPTH-1:0]         hz_ready
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] bubble;
  logic [DEPTH-1:0] load;

  logic [DEPTH-1:0] st_valid;
  logic [DATA_W-1:0] st_data [DEPTH];
  logic [DEPTH-1:0] st_we;
  logic [ADDR_W-1:0] st_addr [DEPTH];
  logic [TNEW_W-1:0] st_tnew [DEPTH];

  logic [DEPTH-1:0] ld_valid;
  logic [DATA_W-1:0] ld_data [DEPTH];
  logic [DEPTH-1:0] ld_we;
  logic [ADDR_W-1:0] ld_addr [DEPTH];
  logic [TNEW_W-1:0] ld_tnew [DEPTH];

  // A stall anywhere downstream freezes this stage as well.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  always_comb begin
    bubble = '0;
    for (int i = 1; i < DEPTH; i++) begin
      bubble[i] = hold[i-1];
    end
    load = ~hold & ~bubble;
  end

  assign in_ready = ~hold[0];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_src
        assign ld_valid[g] = in_valid;
        assign ld_data[g]  = in_data;
        assign ld_we[g]    = in_we;
        assign ld_addr[g]  = in_addr;
        assign ld_tnew[g]  = in_tnew;
      end else begin : g_src
        assign ld_valid[g] = st_valid[g-1];
        assign ld_data[g]  = st_data[g-1];
        assign ld_we[g]    = st_we[g-1];
        assign ld_addr[g]  = st_addr[g-1];
        assign ld_tnew[g]  = TNEW_W'(sat_dec(TNEW_MAX_W'(st_tnew[g-1])));
      end

      pipe_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TNEW_W (TNEW_W)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .load     (load[g]),
        .hold     (hold[g]),
        .bubble   (bubble[g]),
        .flush    (flush[g]),
        .in_valid (ld_valid[g]),
        .in_data  (ld_data[g]),
        .in_we    (ld_we[g]),
        .in_addr  (ld_addr[g]),
        .in_tnew  (ld_tnew[g]),
        .valid    (st_valid[g]),
        .data     (st_data[g]),
        .we       (st_we[g]),
        .addr     (st_addr[g]),
        .tnew     (st_tnew[g])
      );

      assign hz_we[g] = eff_we(st_valid[g], st_we[g], |st_addr[g]);
      assign hz_addr[g*ADDR_W +: ADDR_W] = st_addr[g];
      assign hz_tnew[g*TNEW_W +: TNEW_W] = st_tnew[g];
      assign hz_ready[g] = hz_we[g] & (st_tnew[g] == '0);
    end
  endgenerate

  assign out_valid = st_valid[DEPTH-1];
  assign out_data  = st_data[DEPTH-1];
  assign out_we    = hz_we[DEPTH-1];
  assign out_addr  = st_addr[DEPTH-1];

endmodule

// File: tb/tb_hazard_pipe_chain.sv
// tb/tb_hazard_pipe_chain.sv - directed self-checking bench for hazard_pipe_chain
module tb_hazard_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic [95:0] in_data;
  logic        in_we;
  logic [4:0]  in_addr;
  logic [1:0]  in_tnew;
  logic [2:0]  stall, flush;
  logic [3:0]  stall4, flush4;

  logic        in_ready, out_valid, out_we;
  logic [95:0] out_data;
  logic [4:0]  out_addr;
  logic [2:0]  hz_we, hz_ready;
  logic [14:0] hz_addr;
  logic [5:0]  hz_tnew;

  logic        in_ready4, out_valid4, out_we4;
  logic [95:0] out_data4;
  logic [4:0]  out_addr4;
  logic [3:0]  hz_we4, hz_ready4;
  logic [19:0] hz_addr4;
  logic [7:0]  hz_tnew4;

  int passed = 0;
  int total  = 0;

  hazard_pipe_chain dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_we(in_we),
    .in_addr(in_addr), .in_tnew(in_tnew), .stall(stall), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_we(out_we),
    .out_addr(out_addr), .hz_we(hz_we), .hz_addr(hz_addr), .hz_tnew(hz_tnew),
    .hz_ready(hz_ready)
  );

  hazard_pipe_chain #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_we(in_we),
    .in_addr(in_addr), .in_tnew(in_tnew), .stall(stall4), .flush(flush4),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4), .out_we(out_we4),
    .out_addr(out_addr4), .hz_we(hz_we4), .hz_addr(hz_addr4), .hz_tnew(hz_tnew4),
    .hz_ready(hz_ready4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] a,
                       input logic [1:0] t, input logic [95:0] d);
    in_valid = v;
    in_we    = we;
    in_addr  = a;
    in_tnew  = t;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    stall = '0; flush = '0; stall4 = '0; flush4 = '0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0);
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_hz_we", hz_we, 3'b000);
    chk("rst_hz_addr", hz_addr, 15'h0);
    chk("rst_hz_tnew", hz_tnew, 6'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Free-run: addr 8, tnew 2 counts down to 0 at the last stage.
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd8, 2'd2, 96'hA5A5);
    step();
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0);
    chk("fr1_hz_we", hz_we, 3'b001);
    chk("fr1_hz_tnew", hz_tnew, 6'b00_00_10);
    chk("fr1_hz_ready", hz_ready, 3'b000);
    step();
    chk("fr2_hz_we", hz_we, 3'b010);
    chk("fr2_hz_tnew", hz_tnew, 6'b00_01_00);
    chk("fr2_hz_addr", hz_addr, 15'h0100);
    chk("fr2_out_valid", out_valid, 1'b0);
    step();
    chk("fr3_hz_tnew", hz_tnew, 6'b00_00_00);
    chk("fr3_hz_ready", hz_ready, 3'b100);
    chk("fr3_out_addr", out_addr, 5'd8);
    chk("fr3_out_we", out_we, 1'b1);
    chk("fr3_out_data", out_data, 96'hA5A5);
    chk("sat3_hz_tnew4", hz_tnew4, 8'b00_00_00_00);
    step();
    chk("sat4_hz_tnew4", hz_tnew4, 8'b00_00_00_00);
    chk("sat4_hz_ready4", hz_ready4, 4'b1000);
    chk("sat4_out_addr4", out_addr4, 5'd8);
    chk("fr4_out_valid", out_valid, 1'b0);

    // Saturation with in_tnew = 0 on the 4-deep chain.
    drive(1'b1, 1'b1, 5'd3, 2'd0, 96'h33);
    step();
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0);
    for (int k = 0; k < 4; k++) begin
      chk("satz_hz_tnew4", hz_tnew4, 8'h00);
      chk("satz_hz_ready4", hz_ready4, 4'b0001 << k);
      step();
    end

    // Stall stage 1 for two edges with I1..I3 in flight and I4 waiting.
    drive(1'b1, 1'b1, 5'd1, 2'd0, 96'd1); step();
    drive(1'b1, 1'b1, 5'd2, 2'd0, 96'd2); step();
    drive(1'b1, 1'b1, 5'd3, 2'd0, 96'd3); step();
    chk("pre_hz_addr", hz_addr, {5'd1, 5'd2, 5'd3});
    drive(1'b1, 1'b1, 5'd4, 2'd0, 96'd4);
    stall = 3'b010;
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    step();
    chk("stall1_hz_we", hz_we, 3'b011);
    chk("stall1_hz_addr", hz_addr, {5'd0, 5'd2, 5'd3});
    chk("stall1_out_valid", out_valid, 1'b0);
    step();
    chk("stall2_hz_we", hz_we, 3'b011);
    chk("stall2_hz_addr", hz_addr, {5'd0, 5'd2, 5'd3});
    stall = 3'b000;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    step();
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0);
    chk("rel1_hz_addr", hz_addr, {5'd2, 5'd3, 5'd4});
    chk("rel1_out_data", out_data, 96'd2);
    step();
    chk("rel2_out_data", out_data, 96'd3);
    step();
    chk("rel3_out_data", out_data, 96'd4);
    chk("rel3_hz_we", hz_we, 3'b100);

    // Flush stage 1 while it is stalled.
    drive(1'b1, 1'b1, 5'd5, 2'd0, 96'd5); step();
    drive(1'b1, 1'b1, 5'd6, 2'd0, 96'd6); step();
    chk("prefl_hz_addr", hz_addr, {5'd0, 5'd5, 5'd6});
    drive(1'b1, 1'b1, 5'd7, 2'd0, 96'd7);
    stall = 3'b010;
    flush = 3'b010;
    step();
    chk("fl_hz_we", hz_we, 3'b001);
    chk("fl_hz_addr", hz_addr, {5'd0, 5'd0, 5'd6});
    chk("fl_in_ready", in_ready, 1'b0);
    stall = 3'b000;
    flush = 3'b000;
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0);
    step();
    chk("postfl_hz_we", hz_we, 3'b010);
    chk("postfl_hz_addr", hz_addr, {5'd0, 5'd6, 5'd0});

    // $0 destination: never an effective write, payload still delivered.
    flush = 3'b111;
    step();
    flush = 3'b000;
    chk("flall_hz_addr", hz_addr, 15'h0);
    drive(1'b1, 1'b1, 5'd0, 2'd0, 96'hDEAD);
    step();
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0);
    for (int k = 0; k < 3; k++) begin
      chk("z_hz_we", hz_we, 3'b000);
      chk("z_hz_ready", hz_ready, 3'b000);
      if (k < 2) step();
    end
    chk("z_out_valid", out_valid, 1'b1);
    chk("z_out_we", out_we, 1'b0);
    chk("z_out_data", out_data, 96'hDEAD);

    // Reset during a stall with every stage valid.
    drive(1'b1, 1'b1, 5'd9,  2'd1, 96'd9);  step();
    drive(1'b1, 1'b1, 5'd10, 2'd2, 96'd10); step();
    drive(1'b1, 1'b1, 5'd11, 2'd3, 96'd11); step();
    chk("prerst_hz_we", hz_we, 3'b111);
    stall = 3'b100;
    reset = 1'b1;
    step();
    chk("mrst_hz_we", hz_we, 3'b000);
    chk("mrst_hz_addr", hz_addr, 15'h0);
    chk("mrst_hz_tnew", hz_tnew, 6'h0);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_out_data", out_data, 96'h0);
    chk("mrst_in_ready", in_ready, 1'b0);
    chk("mrst_hz_we4", hz_we4, 4'b0000);
    stall = 3'b000;
    #1;
    chk("mrst_in_ready_rel", in_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
